pc_update_unit: RTL and testbench

Registered program-counter unit for the multicycle datapath. It replaces the old combinational PC-source mux with a parametrised block that holds the PC register, selects among six next-PC sources, and captures EPC on exceptions. It also keeps a small circular return-address stack (RAS) so jal/jr-ra can be served without a register-file read. It sits between the control unit, ALU/ALUOut and the instruction-memory address port.

---
 rtl/pc_update_unit.sv | 132 +++++++++++++
 tb/tb_pc_update_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - registered PC with six-way next-PC select, EPC capture and circular return-address stack
module pc_update_unit #(
    parameter int                 WIDTH      = 32,
    parameter int                 JUMP_BITS  = 28,
    parameter int                 RAS_DEPTH  = 4,
    parameter logic [WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = 32'h0000_0080
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            pc_src,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  branch_taken,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic [JUMP_BITS-1:0]  jump_target,
    input  logic                  exc_req,
    input  logic                  ras_push,
    input  logic [WIDTH-1:0]      ras_push_addr,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      epc,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_underflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic             r_underflow;

    logic             w_load;
    logic             w_pop;
    logic             w_push;
    logic             w_empty;
    logic             w_full;
    logic [PW-1:0]    w_top_ptr;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_pc_next;
    logic [PW-1:0]    w_ptr_next;
    logic [CW-1:0]    w_count_next;
    logic             w_we;
    logic [PW-1:0]    w_waddr;

    // An exception suppresses every other action in the same cycle, RAS included.
    assign w_load    = pc_write | (pc_write_cond & branch_taken);
    assign w_pop     = ~exc_req & w_load & (pc_src == 3'd5);
    assign w_push    = ~exc_req & ras_push;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_top_ptr = r_ptr - PW'(1);
    assign w_top     = r_ras[w_top_ptr];

    always_comb begin
        w_pc_next = r_pc;
        if (exc_req) begin
            w_pc_next = EXC_VECTOR;
        end else if (w_load) begin
            case (pc_src)
                3'd0:    w_pc_next = alu_result;
                3'd1:    w_pc_next = alu_out;
                3'd2:    w_pc_next = {r_pc[WIDTH-1:JUMP_BITS], jump_target};
                3'd3:    w_pc_next = EXC_VECTOR;
                3'd4:    w_pc_next = r_epc;
                3'd5:    w_pc_next = w_empty ? r_pc : w_top;
                default: w_pc_next = r_pc;
            endcase
        end
    end

    // r_ptr is the next free slot; the top entry lives at r_ptr-1.
    always_comb begin
        w_ptr_next   = r_ptr;
        w_count_next = r_count;
        w_we         = 1'b0;
        w_waddr      = r_ptr;
        if (w_pop && !w_empty) begin
            if (w_push) begin
                w_we    = 1'b1;
                w_waddr = w_top_ptr;
            end else begin
                w_ptr_next   = w_top_ptr;
                w_count_next = r_count - CW'(1);
            end
        end else if (w_push) begin
            w_we       = 1'b1;
            w_waddr    = r_ptr;
            w_ptr_next = r_ptr + PW'(1);
            if (!w_full) begin
                w_count_next = r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= RESET_PC;
            r_epc       <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_ptr       <= w_ptr_next;
            r_count     <= w_count_next;
            r_underflow <= w_pop & w_empty;
            if (exc_req) begin
                r_epc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ras[w_waddr] <= ras_push_addr;
        end
    end

    assign pc            = r_pc;
    assign epc           = r_epc;
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed and randomized checks of pc_update_unit against a queue-based model
module tb_pc_update_unit;

    localparam int          WIDTH      = 32;
    localparam int          JUMP_BITS  = 28;
    localparam int          RAS_DEPTH  = 4;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  pc_src = '0;
    logic        pc_write = 1'b0;
    logic        pc_write_cond = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] alu_out = '0;
    logic [27:0] jump_target = '0;
    logic        exc_req = 1'b0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_uf;
    logic [31:0] m_q [$];

    pc_update_unit #(
        .WIDTH(WIDTH), .JUMP_BITS(JUMP_BITS), .RAS_DEPTH(RAS_DEPTH),
        .RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pc_src(pc_src), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
        .alu_result(alu_result), .alu_out(alu_out), .jump_target(jump_target),
        .exc_req(exc_req), .ras_push(ras_push), .ras_push_addr(ras_push_addr),
        .pc(pc), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pc_src = '0; pc_write = 1'b0; pc_write_cond = 1'b0; branch_taken = 1'b0;
        exc_req = 1'b0; ras_push = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_epc = '0; m_uf = 1'b0; m_q.delete();
    endtask

    task automatic model_step();
        logic load;
        logic [31:0] old_pc;
        old_pc = m_pc;
        m_uf = 1'b0;
        load = pc_write | (pc_write_cond & branch_taken);
        if (exc_req) begin
            m_epc = old_pc;
            m_pc  = EXC_VECTOR;
        end else if (load && pc_src == 3'd5) begin
            if (m_q.size() == 0) begin
                m_uf = 1'b1;
            end else begin
                m_pc = m_q.pop_back();
            end
            if (ras_push) m_q.push_back(ras_push_addr);
        end else begin
            if (load) begin
                case (pc_src)
                    3'd0: m_pc = alu_result;
                    3'd1: m_pc = alu_out;
                    3'd2: m_pc = {old_pc[31:28], jump_target};
                    3'd3: m_pc = EXC_VECTOR;
                    3'd4: m_pc = m_epc;
                    default: m_pc = old_pc;
                endcase
            end
            if (ras_push) begin
                if (m_q.size() == RAS_DEPTH) void'(m_q.pop_front());
                m_q.push_back(ras_push_addr);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".epc"}, epc, m_epc);
        chk({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, m_q.size() == 0});
        chk({tag, ".full"}, {31'b0, ras_full}, {31'b0, m_q.size() == RAS_DEPTH});
        chk({tag, ".uf"}, {31'b0, ras_underflow}, {31'b0, m_uf});
    endtask

    // Inputs are set at the falling edge, the DUT samples on the rising edge, results are checked at the next falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        idle();
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_src = 3'd0; pc_write = 1'b1; alu_result = v;
        tick("set_pc");
    endtask

    task automatic push(input logic [31:0] v);
        ras_push = 1'b1; ras_push_addr = v;
        tick("push");
    endtask

    task automatic pop();
        pc_src = 3'd5; pc_write = 1'b1;
        tick("pop");
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset0");
        @(negedge clk);
        reset_n = 1'b1;

        load_pc(32'h40);
        push(32'h77);
        chk("pre_reset_pc", pc, 32'h40);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_pc", pc, 32'h0);
        chk("async_reset_empty", {31'b0, ras_empty}, 32'h1);
        check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;

        load_pc(32'h1000_0010);
        pc_src = 3'd2; jump_target = 28'h000_0400; pc_write = 1'b1;
        tick("jump");
        chk("jump_pc", pc, 32'h1000_0400);

        pc_src = 3'd1; alu_out = 32'h20; pc_write_cond = 1'b1; branch_taken = 1'b0;
        tick("branch_nt");
        chk("branch_nt_pc", pc, 32'h1000_0400);
        pc_src = 3'd1; alu_out = 32'h20; pc_write_cond = 1'b1; branch_taken = 1'b1;
        tick("branch_t");
        chk("branch_t_pc", pc, 32'h20);

        load_pc(32'h44);
        exc_req = 1'b1; pc_write = 1'b1; pc_src = 3'd0; alu_result = 32'hdead_beef;
        ras_push = 1'b1; ras_push_addr = 32'h1234;
        tick("exc");
        chk("exc_pc", pc, 32'h80);
        chk("exc_epc", epc, 32'h44);
        chk("exc_ras_untouched", {31'b0, ras_empty}, 32'h1);
        pc_src = 3'd4; pc_write = 1'b1;
        tick("eret");
        chk("eret_pc", pc, 32'h44);

        pc_src = 3'd6; pc_write = 1'b1;
        tick("reserved6");
        pc_src = 3'd7; pc_write = 1'b1;
        tick("reserved7");

        for (int i = 1; i <= 5; i++) push(32'(i * 16));
        chk("ras_full", {31'b0, ras_full}, 32'h1);
        for (int i = 5; i >= 2; i--) begin
            pop();
            chk("pop_value", pc, 32'(i * 16));
        end
        pop();
        chk("underflow_hold", pc, 32'h20);
        chk("underflow_pulse", {31'b0, ras_underflow}, 32'h1);
        chk("underflow_empty", {31'b0, ras_empty}, 32'h1);
        tick("after_underflow");
        chk("underflow_once", {31'b0, ras_underflow}, 32'h0);

        push(32'h10);
        push(32'h20);
        pc_src = 3'd5; pc_write = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h99;
        tick("push_pop");
        chk("push_pop_pc", pc, 32'h20);
        pop();
        chk("push_pop_newtop", pc, 32'h99);
        pop();
        pop();
        pc_src = 3'd5; pc_write = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h55;
        tick("push_pop_empty");
        chk("push_pop_empty_uf", {31'b0, ras_underflow}, 32'h1);
        chk("push_pop_empty_cnt", {31'b0, ras_empty}, 32'h0);
        pop();
        chk("push_pop_empty_val", pc, 32'h55);

        for (int n = 0; n < 400; n++) begin
            exc_req       = ($urandom_range(0, 15) == 0);
            pc_write      = $urandom_range(0, 1) == 1;
            pc_write_cond = $urandom_range(0, 1) == 1;
            branch_taken  = $urandom_range(0, 1) == 1;
            pc_src        = ($urandom_range(0, 2) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
            alu_result    = $urandom;
            alu_out       = $urandom;
            jump_target   = 28'($urandom);
            ras_push      = $urandom_range(0, 2) == 0;
            ras_push_addr = $urandom;
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
